// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the FUM MIPS multi-cycle controller:
// states, opcode/funct constants, ALU op codes, datapath select codes.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRC_B_RT      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // Every per-cycle datapath control, so a whole cycle can default to '0.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_err;
        logic       busy_fetch;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decoder: maps IR[5:0] to the 4-bit ALU op and flags
// any funct the ALU does not implement.
module mips_alu_decode
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FSM sequencer for the FUM MIPS datapath with mem_ready handshake
// and memory watchdog. Define MC_PERF_CNT_EN to add cycle/instruction counters.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_err,
    output logic       busy_fetch
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state, expire;
    logic [3:0]        dec_alu_op;
    logic              dec_illegal;
    ctrl_t             ctl, ctl_out;

    // The branch decision is taken in the datapath from pc_write_cond and zero.
    logic unused_zero;
    assign unused_zero = zero;

    mips_alu_decode u_alu_decode (
        .funct   (funct),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // The last permitted wait cycle still completes if mem_ready arrives in it.
    assign expire    = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state_next != state) || expire)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        ctl        = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read   = 1'b1;
                ctl.alu_src_b  = SRC_B_FOUR;
                ctl.alu_op     = ALU_ADD;
                ctl.pc_source  = PC_SRC_ALU;
                ctl.busy_fetch = 1'b1;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_next   = S_DECODE;
                end else if (expire) begin
                    ctl.mem_err = 1'b1;
                end
            end
            S_DECODE: begin
                ctl.alu_src_b = SRC_B_IMM_SH2;
                ctl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_ADDI:      state_next = S_I_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        state_next     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_ADD;
                state_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (expire) begin
                    ctl.mem_err = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (expire) begin
                    ctl.mem_err = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_RT;
                ctl.alu_op    = dec_alu_op;
                if (dec_illegal) begin
                    ctl.illegal_op = 1'b1;
                    state_next     = S_FETCH;
                end else begin
                    state_next = S_R_WB;
                end
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_next    = S_FETCH;
            end
            S_I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.alu_op    = ALU_ADD;
                state_next    = S_I_WB;
            end
            S_I_WB: begin
                ctl.reg_write = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRC_B_RT;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PC_SRC_ALUOUT;
                state_next        = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PC_SRC_JUMP;
                state_next    = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Gating with reset_n forces every enable low the instant reset asserts.
    assign ctl_out = reset_n ? ctl : '0;

    assign pc_write      = ctl_out.pc_write;
    assign pc_write_cond = ctl_out.pc_write_cond;
    assign i_or_d        = ctl_out.i_or_d;
    assign mem_read      = ctl_out.mem_read;
    assign mem_write     = ctl_out.mem_write;
    assign ir_write      = ctl_out.ir_write;
    assign mem_to_reg    = ctl_out.mem_to_reg;
    assign reg_dst       = ctl_out.reg_dst;
    assign reg_write     = ctl_out.reg_write;
    assign alu_src_a     = ctl_out.alu_src_a;
    assign alu_src_b     = ctl_out.alu_src_b;
    assign alu_op        = ctl_out.alu_op;
    assign pc_source     = ctl_out.pc_source;
    assign illegal_op    = ctl_out.illegal_op;
    assign mem_err       = ctl_out.mem_err;
    assign busy_fetch    = ctl_out.busy_fetch;

`ifdef MC_PERF_CNT_EN
    logic instr_done;
    assign instr_done = (state != S_FETCH) && (state_next == S_FETCH)
                        && !ctl.illegal_op && !ctl.mem_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_done)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: an instruction-level model expands
// random and directed instructions into per-cycle stimulus and expected controls.
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic       illegal_op, mem_err, busy_fetch;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .mem_err(mem_err),
        .busy_fetch(busy_fetch)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op, mem_err, busy_fetch;
    } ctl_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op, fn;
        logic       z, rdy;
    } drv_t;

    typedef struct {
        ctl_t        ctl;
        ctl_t        mask;
        int unsigned cyc;
        int unsigned ins;
    } exp_t;

    drv_t        drv_q[$];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned g_cyc = 0;
    int unsigned g_ins = 0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;
    logic        cur_z = 1'b0;
    logic [5:0]  legal_fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    ctl_t got;
    assign got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_op, mem_err, busy_fetch};

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    endfunction

    function automatic logic [3:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic ctl_t c_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_read   = 1'b1;
        c.alu_src_b  = 2'd1;
        c.alu_op     = 4'b0010;
        c.busy_fetch = 1'b1;
        c.ir_write   = rdy;
        c.pc_write   = rdy;
        return c;
    endfunction

    // One cycle of stimulus plus its expected controls and counter values.
    task automatic emit(input logic rst, input logic rdy, input ctl_t c, input ctl_t m);
        drv_t d;
        exp_t e;
        d.rst_n = rst; d.op = cur_op; d.fn = cur_fn; d.z = cur_z; d.rdy = rdy;
        e.ctl = c; e.mask = m;
        e.cyc = rst ? g_cyc : 0;
        e.ins = rst ? g_ins : 0;
        drv_q.push_back(d);
        exp_q.push_back(e);
        if (rst) g_cyc++;
        else begin
            g_cyc = 0;
            g_ins = 0;
        end
    endtask

    // Non-memory cycle: mem_ready is random there and must be ignored.
    task automatic plain(input ctl_t c);
        emit(1'b1, 1'($urandom_range(0, 1)), c, '1);
    endtask

    // kind 0 = fetch, 1 = data read, 2 = data write; w = stall cycles before ready.
    task automatic mem_phase(input int kind, input int w, output bit ok);
        ctl_t c;
        logic rdy;
        int   n;
        n = (w >= TO) ? TO : w + 1;
        for (int i = 0; i < n; i++) begin
            rdy = (i == w);
            c   = '0;
            case (kind)
                0:       c = c_fetch(rdy);
                1:       begin c.mem_read = 1'b1;  c.i_or_d = 1'b1; end
                default: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            endcase
            if (w >= TO && i == TO - 1) c.mem_err = 1'b1;
            emit(1'b1, rdy, c, '1);
        end
        ok = (w < TO);
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int wf, input int wm);
        bit   ok;
        ctl_t c, m;
        cur_op = op; cur_fn = fn; cur_z = z;
        mem_phase(0, wf, ok);
        while (!ok) mem_phase(0, $urandom_range(0, 2), ok);
        c = '0; c.alu_src_b = 2'd3; c.alu_op = 4'b0010;
        if (!legal_op(op)) begin
            c.illegal_op = 1'b1;
            plain(c);
            return;
        end
        plain(c);
        c = '0;
        case (op)
            6'h23, 6'h2B: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 4'b0010;
                plain(c);
                mem_phase((op == 6'h23) ? 1 : 2, wm, ok);
                if (ok) begin
                    if (op == 6'h23) begin
                        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                        plain(c);
                    end
                    g_ins++;
                end
            end
            6'h00: begin
                c.alu_src_a = 1'b1;
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
                    c.alu_op = fn_alu(fn);
                    plain(c);
                    c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
                    plain(c);
                    g_ins++;
                end else begin
                    c.illegal_op = 1'b1;
                    m = '1; m.alu_op = '0;
                    emit(1'b1, 1'($urandom_range(0, 1)), c, m);
                end
            end
            6'h08: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 4'b0010;
                plain(c);
                c = '0; c.reg_write = 1'b1;
                plain(c);
                g_ins++;
            end
            6'h04: begin
                c.alu_src_a = 1'b1; c.alu_op = 4'b0110;
                c.pc_write_cond = 1'b1; c.pc_source = 2'd1;
                plain(c);
                g_ins++;
            end
            default: begin
                c.pc_write = 1'b1; c.pc_source = 2'd2;
                plain(c);
                g_ins++;
            end
        endcase
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2))
                                           : int'($urandom_range(0, 2));
    endfunction

    // Driver: applies one queued stimulus cycle just after each rising edge.
    initial begin
        drv_t d;
        forever begin
            @(posedge clock);
            #1;
            if (drv_q.size() > 0) begin
                d = drv_q.pop_front();
                reset_n = d.rst_n; opcode = d.op; funct = d.fn;
                zero = d.z; mem_ready = d.rdy;
            end
        end
    end

    // Monitor: compares the DUT's controls on every falling edge with a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (((got ^ e.ctl) & e.mask) != '0) begin
                    bad++;
                    $display("FAIL ctl t=%0t op=%h fn=%h got=%b want=%b mask=%b",
                             $time, opcode, funct, got, e.ctl, e.mask);
                end
`ifdef MC_PERF_CNT_EN
                total++;
                if (cycle_cnt != e.cyc) begin
                    bad++;
                    $display("FAIL cycle_cnt t=%0t got=%0d want=%0d", $time, cycle_cnt, e.cyc);
                end
                total++;
                if (instr_cnt != e.ins) begin
                    bad++;
                    $display("FAIL instr_cnt t=%0t got=%0d want=%0d", $time, instr_cnt, e.ins);
                end
`endif
            end
        end
    end

    initial begin
        bit         ok;
        int         r;
        logic [5:0] op, fn;
        ctl_t       c;

        emit(1'b0, 1'b0, '0, '1);
        emit(1'b0, 1'b1, '0, '1);

        do_instr(6'h23, 6'h00, 1'b0, 0, 0);   // lw, zero wait states
        do_instr(6'h2B, 6'h00, 1'b0, 0, 3);   // sw, 3 stalls in MEM_WR
        do_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        do_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j
        do_instr(6'h00, 6'h22, 1'b0, 0, 0);   // sub
        do_instr(6'h00, 6'h3F, 1'b0, 0, 0);   // illegal funct
        do_instr(6'h3F, 6'h20, 1'b0, 0, 0);   // illegal opcode
        do_instr(6'h08, 6'h00, 1'b0, TO, 0);  // fetch watchdog abort, refetch
        do_instr(6'h23, 6'h00, 1'b0, 0, TO - 1); // ready in expiry cycle wins
        do_instr(6'h23, 6'h00, 1'b0, 1, TO + 1); // data read abort

        for (int k = 0; k < 80; k++) begin
            r  = $urandom_range(0, 9);
            fn = legal_fns[$urandom_range(0, 4)];
            case (r)
                0, 1:    op = 6'h23;
                2:       op = 6'h2B;
                3, 4:    op = 6'h00;
                5:       op = 6'h08;
                6:       op = 6'h04;
                7:       op = 6'h02;
                8: begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
                default: op = 6'($urandom_range(0, 63));
            endcase
            do_instr(op, fn, 1'($urandom_range(0, 1)), rand_wait(), rand_wait());
        end

        // Reset asserted while a lw sits in its write-back cycle.
        cur_op = 6'h23; cur_fn = 6'h00;
        mem_phase(0, 0, ok);
        c = '0; c.alu_src_b = 2'd3; c.alu_op = 4'b0010; plain(c);
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 4'b0010; plain(c);
        mem_phase(1, 0, ok);
        emit(1'b0, 1'b1, '0, '1);
        emit(1'b0, 1'b0, '0, '1);
        do_instr(6'h02, 6'h00, 1'b0, 0, 0);
        do_instr(6'h23, 6'h00, 1'b0, 1, 1);

        for (int i = 0; i < 20000 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit=500000", $time);
        $fatal(1, "bench time limit");
    end

endmodule
